skewed_fifo_array: RTL and testbench

Parametrised single-clock array of independent channel FIFOs that buffers operand rows/columns and feeds them into the systolic PE array. It generalises the fixed 9×8-bit dual-clock FIFO array: width, depth and channel count are parameters, writes can be broadcast to several channels, and a built-in skew engine drains all channels in diagonal (staggered) order from a single start pulse.

---
 rtl/fifo_array_pkg.sv | 18 +
 rtl/sync_fifo_ch.sv | 88 ++++++++
 rtl/skewed_fifo_array.sv | 101 ++++++++++
 tb/tb_skewed_fifo_array.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_array_pkg.sv
// rtl/fifo_array_pkg.sv - shared types, default parameters and slice helper for skewed_fifo_array
package fifo_array_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_DEPTH    = 256;
    localparam int DEF_CHANNELS = 9;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } skew_state_t;

    // Low bit of channel ch's slice in a packed per-channel bus.
    function automatic int slice_lo(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/sync_fifo_ch.sv
// rtl/sync_fifo_ch.sv - one channel FIFO with registered read port and sticky error flags
// Optional occupancy output under FIFO_ARRAY_COUNT_EN.
module sync_fifo_ch #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_wr,
    input  logic              i_rd,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_overflow,
    output logic              o_underflow
`ifdef FIFO_ARRAY_COUNT_EN
    ,
    output logic [ADDR_W:0]   o_count
`endif
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W:0]   r_count;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_overflow;
    logic              r_underflow;
    logic              w_push;
    logic              w_pop;

    assign o_full   = (r_count == (ADDR_W+1)'(DEPTH));
    assign o_empty  = (r_count == '0);
    // Status is pre-operation: a full channel drops a write even when popped this cycle.
    assign w_push   = i_wr && !o_full;
    assign w_pop    = i_rd && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_valid <= w_pop;
            if (w_push) begin
                r_wptr <= r_wptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + ADDR_W'(1);
                r_data <= r_mem[r_rptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
                default: r_count <= r_count;
            endcase
            if (i_wr && o_full) begin
                r_overflow <= 1'b1;
            end
            if (i_rd && o_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;
`ifdef FIFO_ARRAY_COUNT_EN
    assign o_count     = r_count;
`endif

endmodule

// File: rtl/skewed_fifo_array.sv
// rtl/skewed_fifo_array.sv - channel FIFO array with broadcast writes and diagonal skew drain
// Optional count_bus output under FIFO_ARRAY_COUNT_EN.
module skewed_fifo_array
    import fifo_array_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int CHANNELS = DEF_CHANNELS
) (
    input  logic                       clk,
    input  logic                       clear_n,
    input  logic [DATA_W-1:0]          in_bus,
    input  logic [CHANNELS-1:0]        w_en,
    input  logic [CHANNELS-1:0]        r_en,
    input  logic                       skew_start,
    input  logic [ADDR_W:0]            skew_len,
    output logic [DATA_W*CHANNELS-1:0] out_bus,
    output logic [CHANNELS-1:0]        out_valid,
    output logic [CHANNELS-1:0]        full,
    output logic [CHANNELS-1:0]        empty,
    output logic                       skew_busy,
    output logic [CHANNELS-1:0]        overflow,
    output logic [CHANNELS-1:0]        underflow
`ifdef FIFO_ARRAY_COUNT_EN
    ,
    output logic [(ADDR_W+1)*CHANNELS-1:0] count_bus
`endif
);

    // Wide enough for the last diagonal step L + CHANNELS - 2 with L up to DEPTH.
    localparam int CYC_W = ADDR_W + $clog2(CHANNELS) + 2;

    skew_state_t          r_state;
    logic [CYC_W-1:0]     r_cyc;
    logic [ADDR_W:0]      r_len;
    logic [ADDR_W:0]      w_len_sat;
    logic [CYC_W-1:0]     w_last;
    logic [CHANNELS-1:0]  w_skew_rd;
    logic [CHANNELS-1:0]  w_rd;

    assign w_len_sat = (skew_len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : skew_len;
    assign w_last    = CYC_W'(r_len) + CYC_W'(CHANNELS) - CYC_W'(2);
    assign skew_busy = (r_state == RUN);

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            r_state <= IDLE;
            r_cyc   <= '0;
            r_len   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (skew_start && (skew_len != '0)) begin
                        r_state <= RUN;
                        r_len   <= w_len_sat;
                        r_cyc   <= '0;
                    end
                end
                RUN: begin
                    if (r_cyc == w_last) begin
                        r_state <= IDLE;
                    end else begin
                        r_cyc <= r_cyc + CYC_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        // Channel g reads during diagonal steps g .. g+L-1.
        assign w_skew_rd[g] = skew_busy && (r_cyc >= CYC_W'(g)) &&
                              (r_cyc < CYC_W'(g) + CYC_W'(r_len));
        assign w_rd[g]      = r_en[g] | w_skew_rd[g];

        sync_fifo_ch #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_ch (
            .clk         (clk),
            .clear_n     (clear_n),
            .i_data      (in_bus),
            .i_wr        (w_en[g]),
            .i_rd        (w_rd[g]),
            .o_data      (out_bus[slice_lo(g, DATA_W) +: DATA_W]),
            .o_valid     (out_valid[g]),
            .o_full      (full[g]),
            .o_empty     (empty[g]),
            .o_overflow  (overflow[g]),
            .o_underflow (underflow[g])
`ifdef FIFO_ARRAY_COUNT_EN
            ,
            .o_count     (count_bus[slice_lo(g, ADDR_W+1) +: ADDR_W+1])
`endif
        );
    end

endmodule

// File: tb/tb_skewed_fifo_array.sv
// tb/tb_skewed_fifo_array.sv - scoreboard bench for skewed_fifo_array
module tb_skewed_fifo_array;

    localparam int DW    = 8;
    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int CH    = 9;

    logic             clk = 1'b0;
    logic             clear_n;
    logic [DW-1:0]    in_bus;
    logic [CH-1:0]    w_en;
    logic [CH-1:0]    r_en;
    logic             skew_start;
    logic [AW:0]      skew_len;
    logic [DW*CH-1:0] out_bus;
    logic [CH-1:0]    out_valid;
    logic [CH-1:0]    full;
    logic [CH-1:0]    empty;
    logic             skew_busy;
    logic [CH-1:0]    overflow;
    logic [CH-1:0]    underflow;
`ifdef FIFO_ARRAY_COUNT_EN
    logic [(AW+1)*CH-1:0] count_bus;
`endif

    skewed_fifo_array #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .CHANNELS(CH)) dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .in_bus     (in_bus),
        .w_en       (w_en),
        .r_en       (r_en),
        .skew_start (skew_start),
        .skew_len   (skew_len),
        .out_bus    (out_bus),
        .out_valid  (out_valid),
        .full       (full),
        .empty      (empty),
        .skew_busy  (skew_busy),
        .overflow   (overflow),
        .underflow  (underflow)
`ifdef FIFO_ARRAY_COUNT_EN
        ,
        .count_bus  (count_bus)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int            t;
        logic [DW-1:0] d;
    } exp_t;

    int            cyc_count = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    bit            mon_en = 1'b0;
    exp_t          sb [CH][$];
    logic [DW-1:0] mq [CH][$];
    logic [DW-1:0] m_out [CH];
    bit            m_ovf [CH];
    bit            m_udf [CH];
    int            sk_p = 0;
    int            sk_L = 0;

    always @(posedge clk) cyc_count <= cyc_count + 1;

    function automatic bit busy_at(input int c);
        return (sk_L != 0) && (c >= sk_p) && (c <= sk_p + sk_L + CH - 2);
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_count);
        end
    endtask

    // Reference model: each channel is a plain queue; skew reads follow the diagonal
    // schedule counted in absolute sampling edges from the accepted start edge p.
    task automatic model_step(input int p, input logic rn, input logic [CH-1:0] we,
                              input logic [CH-1:0] re, input logic [DW-1:0] d,
                              input logic st, input logic [AW:0] len);
        if (!rn) begin
            for (int i = 0; i < CH; i++) begin
                mq[i].delete();
                sb[i].delete();
                m_out[i] = '0;
                m_ovf[i] = 1'b0;
                m_udf[i] = 1'b0;
            end
            sk_L = 0;
            return;
        end
        for (int i = 0; i < CH; i++) begin
            bit srd;
            bit was_full;
            bit rd;
            srd      = (sk_L != 0) && (p >= sk_p + 1 + i) && (p < sk_p + 1 + i + sk_L);
            rd       = re[i] || srd;
            was_full = (mq[i].size() == DEPTH);
            if (rd) begin
                if (mq[i].size() == 0) begin
                    m_udf[i] = 1'b1;
                end else begin
                    exp_t e;
                    m_out[i] = mq[i].pop_front();
                    e.t = p;
                    e.d = m_out[i];
                    sb[i].push_back(e);
                end
            end
            if (we[i]) begin
                if (was_full) m_ovf[i] = 1'b1;
                else mq[i].push_back(d);
            end
        end
        if (st && (len != 0) && !busy_at(p - 1)) begin
            sk_p = p;
            sk_L = (int'(len) > DEPTH) ? DEPTH : int'(len);
        end
    endtask

    task automatic step(input logic rn, input logic [CH-1:0] we, input logic [CH-1:0] re,
                        input logic [DW-1:0] d, input logic st, input logic [AW:0] len);
        @(negedge clk);
        clear_n    = rn;
        w_en       = we;
        r_en       = re;
        in_bus     = d;
        skew_start = st;
        skew_len   = len;
        model_step(cyc_count + 1, rn, we, re, d, st, len);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic preload(input int n);
        for (int k = 0; k < n; k++) step(1'b1, '1, '0, DW'($urandom), 1'b0, '0);
    endtask

    // Monitor: pop the scoreboard on every out_valid and check the status outputs.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            logic [CH-1:0]    e_full;
            logic [CH-1:0]    e_empty;
            logic [CH-1:0]    e_ovf;
            logic [CH-1:0]    e_udf;
            logic [DW*CH-1:0] e_bus;
            for (int i = 0; i < CH; i++) begin
                exp_t e;
                if (out_valid[i] === 1'b1) begin
                    if (sb[i].size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL spurious_valid ch%0d: got valid expected none (cycle %0d)", i, cyc_count);
                    end else begin
                        e = sb[i].pop_front();
                        chk($sformatf("rd_time ch%0d", i), 128'(cyc_count), 128'(e.t));
                        chk($sformatf("rd_data ch%0d", i), 128'(out_bus[i*DW +: DW]), 128'(e.d));
                    end
                end else if (sb[i].size() != 0 && sb[i][0].t <= cyc_count) begin
                    e = sb[i].pop_front();
                    n_cmp++;
                    n_bad++;
                    $display("FAIL missing_valid ch%0d: got %b expected 1 (cycle %0d)", i, out_valid[i], cyc_count);
                end
                e_full[i]  = (mq[i].size() == DEPTH);
                e_empty[i] = (mq[i].size() == 0);
                e_ovf[i]   = m_ovf[i];
                e_udf[i]   = m_udf[i];
                e_bus[i*DW +: DW] = m_out[i];
`ifdef FIFO_ARRAY_COUNT_EN
                chk($sformatf("count ch%0d", i), 128'(count_bus[i*(AW+1) +: AW+1]), 128'(mq[i].size()));
`endif
            end
            chk("full", 128'(full), 128'(e_full));
            chk("empty", 128'(empty), 128'(e_empty));
            chk("overflow", 128'(overflow), 128'(e_ovf));
            chk("underflow", 128'(underflow), 128'(e_udf));
            chk("out_bus", 128'(out_bus), 128'(e_bus));
            chk("skew_busy", 128'(skew_busy), 128'(busy_at(cyc_count)));
        end
    end

    initial begin
        logic [CH-1:0] oh;
        logic [CH-1:0] we;
        logic [CH-1:0] re;
        clear_n = 1'b0; in_bus = '0; w_en = '0; r_en = '0; skew_start = 1'b0; skew_len = '0;

        step(1'b0, '0, '0, '0, 1'b0, '0);
        mon_en = 1'b1;
        step(1'b0, '0, '0, '0, 1'b0, '0);

        // One-hot writes then one-hot reads
        for (int i = 0; i < CH; i++) begin
            oh = '0; oh[i] = 1'b1;
            step(1'b1, oh, '0, DW'(i + 1), 1'b0, '0);
        end
        for (int i = 0; i < CH; i++) begin
            oh = '0; oh[i] = 1'b1;
            step(1'b1, '0, oh, '0, 1'b0, '0);
        end
        idle(2);

        // Broadcast write, read everything back
        step(1'b1, '1, '0, 8'hA5, 1'b0, '0);
        step(1'b1, '0, '1, '0, 1'b0, '0);
        idle(2);

        // Fill channel 0, overflow with concurrent read, then drain past empty
        oh = '0; oh[0] = 1'b1;
        for (int k = 0; k < DEPTH; k++) step(1'b1, oh, '0, DW'($urandom), 1'b0, '0);
        step(1'b1, oh, oh, 8'hEE, 1'b0, '0);
        for (int k = 0; k < 3; k++) step(1'b1, oh, '0, DW'($urandom), 1'b0, '0);
        for (int k = 0; k < DEPTH + 2; k++) step(1'b1, '0, oh, '0, 1'b0, '0);
        idle(2);

        // Skew drain of 3, second start mid-run must be ignored
        step(1'b0, '0, '0, '0, 1'b0, '0);
        preload(3);
        step(1'b1, '0, '0, '0, 1'b1, 9'd3);
        for (int k = 0; k < 14; k++) step(1'b1, '0, '0, '0, (k == 3), 9'd5);

        // Skew of 4 over 3 entries underflows, then reset mid-drain
        preload(3);
        step(1'b1, '0, '0, '0, 1'b1, 9'd4);
        idle(6);
        step(1'b0, '0, '0, '0, 1'b0, '0);
        idle(3);

        // Zero-length start ignored; oversized length saturates to DEPTH
        preload(2);
        step(1'b1, '0, '0, '0, 1'b1, 9'd0);
        idle(2);
        step(1'b1, '0, '0, '0, 1'b1, 9'h1F0);
        idle(DEPTH + CH + 4);

        // Randomised traffic
        for (int k = 0; k < 800; k++) begin
            for (int i = 0; i < CH; i++) begin
                we[i] = ($urandom_range(0, 9) < 4);
                re[i] = ($urandom_range(0, 9) < 2);
            end
            step(($urandom_range(0, 299) != 0), we, re, DW'($urandom),
                 ($urandom_range(0, 14) == 0), (AW+1)'($urandom_range(0, 12)));
        end
        idle(40);

        for (int i = 0; i < CH; i++) begin
            chk($sformatf("sb_drained ch%0d", i), 128'(sb[i].size()), 128'(0));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
